// File: rtl/ram_loader.sv
// ram_loader: write-side initiator that fills the program RAM from a
// valid/ready byte stream at addresses 0..LAST_ADDR, holding the CPU off
// via BUSY until the load is complete.
// Optional feature macro: RAM_LOADER_VERIFY_EN adds a read-back checksum
// pass (VERIFY state) that reports a mismatch on ERR.
module ram_loader #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int LAST_ADDR = 15
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          START,
    input  logic          IN_VALID,
    input  logic [DW-1:0] IN_DATA,
    output logic          IN_READY,
    output logic          WE,
    output logic [AW-1:0] WA,
    output logic [DW-1:0] WD,
    output logic          RE,
    output logic [AW-1:0] RA,
    input  logic [DW-1:0] Q,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
`ifdef RAM_LOADER_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          we_q,    we_d;
    logic [AW-1:0] wa_q,    wa_d;
    logic [DW-1:0] wd_q,    wd_d;

`ifdef RAM_LOADER_VERIFY_EN
    logic [DW-1:0] sum_q,   sum_d;
    logic [DW-1:0] rsum_q,  rsum_d;
    logic [AW-1:0] ra_q,    ra_d;
    logic          err_q,   err_d;
`endif

    // State, address counter and registered RAM write port
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    // Checksum, read-back address and sticky error flag
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sum_q  <= '0;
            rsum_q <= '0;
            ra_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            rsum_q <= rsum_d;
            ra_q   <= ra_d;
            err_q  <= err_d;
        end
    end
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
`ifdef RAM_LOADER_VERIFY_EN
        sum_d   = sum_q;
        rsum_d  = rsum_q;
        ra_d    = ra_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
`ifdef RAM_LOADER_VERIFY_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (IN_VALID) begin
                    we_d  = 1'b1;
                    wa_d  = addr_q;
                    wd_d  = IN_DATA;
`ifdef RAM_LOADER_VERIFY_EN
                    sum_d = sum_q + IN_DATA;
`endif
                    // Counter parks on the last address instead of wrapping
                    if (addr_q == LAST) begin
                        state_d = S_FLUSH;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
`ifdef RAM_LOADER_VERIFY_EN
                state_d = S_VERIFY;
                ra_d    = '0;
                rsum_d  = '0;
`else
                state_d = S_DONE;
`endif
            end
`ifdef RAM_LOADER_VERIFY_EN
            S_VERIFY: begin
                // The final word is folded in combinationally so the compare
                // lands on the same edge that leaves VERIFY
                rsum_d = rsum_q + Q;
                if (ra_q == LAST) begin
                    err_d   = (rsum_d != sum_q);
                    state_d = S_DONE;
                end else begin
                    ra_d = ra_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign IN_READY = (state_q == S_LOAD);
    assign WE       = we_q;
    assign WA       = wa_q;
    assign WD       = wd_q;
    assign DONE     = (state_q == S_DONE);
    assign BUSY     = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef RAM_LOADER_VERIFY_EN
    assign RE  = (state_q == S_VERIFY);
    assign RA  = (state_q == S_VERIFY) ? ra_q : '0;
    assign ERR = err_q;
`else
    logic q_unused;
    assign q_unused = ^Q;
    assign RE  = 1'b0;
    assign RA  = '0;
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a scoreboard of expected RAM writes is filled as
// bytes are handed over, and a monitor pops and compares on every WE strobe.
// Honours RAM_LOADER_VERIFY_EN to match the DUT build.
module tb_ram_loader;

    logic       CLK;
    logic       CLR;
    logic       START;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic       WE;
    logic [3:0] WA;
    logic [7:0] WD;
    logic       RE;
    logic [3:0] RA;
    logic [7:0] Q;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    ram_loader #(.AW(4), .DW(8), .LAST_ADDR(15)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .IN_VALID(IN_VALID),
        .IN_DATA(IN_DATA), .IN_READY(IN_READY), .WE(WE), .WA(WA), .WD(WD),
        .RE(RE), .RA(RA), .Q(Q), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb_q[$];
    wr_t        mon_e;
    logic [7:0] ram [16];
    logic [7:0] bytes_a [16];
    logic       corrupt;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_wr     = 0;
    int         re_seen  = 0;
    int         exp_addr = 0;
    int         cyc      = 0;
    int         start_cyc = 0;
    int         done_cyc  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model; a bench-controlled fault flips bit 0 of word 7 on read-back
    always @(posedge CLK) if (WE) ram[WA] <= WD;
    assign Q = RE ? (ram[RA] ^ {7'b0, corrupt && (RA == 4'd7)}) : 8'h00;

    // Write monitor: every WE strobe must match the oldest expected write
    always @(negedge CLK) begin
        if (RE) re_seen++;
        if (WE) begin
            n_wr++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: WA=%0d WD=0x%02h, no write expected", WA, WD);
            end else begin
                mon_e = sb_q.pop_front();
                if (WA !== mon_e.a || WD !== mon_e.d) begin
                    n_fail++;
                    $display("FAIL write: got WA=%0d WD=0x%02h, expected WA=%0d WD=0x%02h",
                             WA, WD, mon_e.a, mon_e.d);
                end
            end
            if (RE) begin
                n_fail++;
                $display("FAIL we_re_overlap: WE=1 RE=1, expected RE=0");
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, 32'({IN_READY, WE, WA, WD, RE, RA, BUSY, DONE, ERR}), 32'h0);
    endtask

    task automatic do_start();
        START = 1'b1;
        @(posedge CLK); #1;
        start_cyc = cyc;
        START = 1'b0;
        exp_addr = 0;
        n_wr = 0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        forever begin
            @(negedge CLK);
            if (IN_READY) begin
                sb_q.push_back('{a: 4'(exp_addr), d: d});
                exp_addr++;
                break;
            end
            n++;
            if (n > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: IN_READY=0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) send(bytes_a[i]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (DONE) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout: DONE=0 after %0d cycles, expected 1", n);
                break;
            end
        end
        done_cyc = cyc;
    endtask

    initial begin
        CLR = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; corrupt = 1'b0;
        repeat (2) @(posedge CLK); #1;
        check_idle("reset_outputs");
        CLR = 1'b0;

        // IN_VALID while idle must not be accepted
        IN_VALID = 1'b1; IN_DATA = 8'hAA;
        repeat (3) begin
            @(negedge CLK);
            check("idle_in_ready", 32'(IN_READY), 32'h0);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check("idle_no_write", 32'(n_wr), 32'h0);
        check("idle_busy", 32'(BUSY), 32'h0);

        // Continuous stream
        bytes_a[0] = 8'h1E; bytes_a[1] = 8'hF0;
        for (int i = 2; i < 14; i++) bytes_a[i] = 8'h00;
        bytes_a[14] = 8'h0C; bytes_a[15] = 8'h00;
        do_start();
        load_all();
        wait_done();
`ifdef RAM_LOADER_VERIFY_EN
        check("stream_latency", 32'(done_cyc - start_cyc + 1), 32'd34);
`else
        check("stream_latency", 32'(done_cyc - start_cyc + 1), 32'd18);
`endif
        check("stream_writes", 32'(n_wr), 32'd16);
        check("stream_sb_empty", 32'(sb_q.size()), 32'h0);
        check("stream_done", 32'(DONE), 32'h1);
        check("stream_err", 32'(ERR), 32'h0);
        check("stream_busy", 32'(BUSY), 32'h0);
        check("stream_ready", 32'(IN_READY), 32'h0);
        check("ram0", 32'(ram[0]), 32'h1E);
        check("ram1", 32'(ram[1]), 32'hF0);
        check("ram14", 32'(ram[14]), 32'h0C);

        // Toggled IN_VALID, with a stray START mid-load
        for (int i = 0; i < 16; i++) bytes_a[i] = 8'(i * 17 + 3);
        do_start();
        for (int i = 0; i < 16; i++) begin
            send(bytes_a[i]);
            if (i == 7) START = 1'b1;
            @(negedge CLK);
            check("toggle_busy", 32'(BUSY), 32'h1);
            @(posedge CLK); #1;
            START = 1'b0;
        end
        wait_done();
        check("toggle_writes", 32'(n_wr), 32'd16);
        check("toggle_sb_empty", 32'(sb_q.size()), 32'h0);
        check("toggle_err", 32'(ERR), 32'h0);
        check("toggle_ram15", 32'(ram[15]), 32'(8'(15 * 17 + 3)));

        // CLR after the fifth byte has reached the RAM
        do_start();
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
        @(negedge CLK);
        @(posedge CLK); #1;
        CLR = 1'b1;
        #1;
        check_idle("clr_outputs");
        @(posedge CLK); #1;
        CLR = 1'b0;
        check_idle("clr_released");
        check("clr_writes", 32'(n_wr), 32'd5);
        for (int i = 0; i < 5; i++) check("clr_ram_kept", 32'(ram[i]), 32'(8'hA0 + i));
        check("clr_ram5_old", 32'(ram[5]), 32'(8'(5 * 17 + 3)));

        // Reload after CLR starts again at address 0
        for (int i = 0; i < 16; i++) bytes_a[i] = 8'(8'h50 + i);
        do_start();
        load_all();
        wait_done();
        check("reload_writes", 32'(n_wr), 32'd16);
        check("reload_sb_empty", 32'(sb_q.size()), 32'h0);
        check("reload_ram0", 32'(ram[0]), 32'h50);
        check("reload_err", 32'(ERR), 32'h0);

`ifdef RAM_LOADER_VERIFY_EN
        // Corrupted read-back flags ERR; the next START clears it
        corrupt = 1'b1;
        do_start();
        load_all();
        wait_done();
        check("corrupt_err", 32'(ERR), 32'h1);
        check("corrupt_done", 32'(DONE), 32'h1);
        check("corrupt_latency", 32'(done_cyc - start_cyc + 1), 32'd34);
        corrupt = 1'b0;
        do_start();
        check("restart_err_clr", 32'(ERR), 32'h0);
        check("restart_done_clr", 32'(DONE), 32'h0);
        load_all();
        wait_done();
        check("clean_err", 32'(ERR), 32'h0);
        check("re_used", 32'(re_seen > 0), 32'h1);
`else
        check("re_never", 32'(re_seen), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
